// File: rtl/inv_monitor_if.sv
// Signal bundle between an inverter observer and its environment.
// Parameterised on the counter width so it matches the monitor instance.
interface inv_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             clr;
  logic             a;
  logic             y;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] chk_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output en, clr, a, y,
    input  busy, err, chk_cnt, fail_cnt
  );

  modport slave (
    input  en, clr, a, y,
    output busy, err, chk_cnt, fail_cnt
  );
endinterface

// File: rtl/inv_monitor.sv
// Clocked checker for an inverter cell: compares y against ~a once a has been stable
// for SETTLE cycles. Optional INV_MON_HALT_EN freezes the monitor on the first mismatch.
module inv_monitor #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 8
) (
  input logic         clk,
  input logic         rst,
  inv_monitor_if.slave mon
);

  localparam int unsigned        TMR_W    = 4;
  localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(SETTLE);
  localparam logic [TMR_W-1:0]   TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

`ifdef INV_MON_HALT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_HALT} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK} state_t;
`endif

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   chk_q, chk_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               a_q;
  logic               change;
  logic               halted;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign change = (mon.a != a_q);

`ifdef INV_MON_HALT_EN
  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

  // Next-state, timer and counter update; clr outranks en, which outranks normal flow.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    chk_d   = chk_q;
    fail_d  = fail_q;
    err_d   = err_q;

    if (mon.clr) begin
      state_d = ST_IDLE;
      chk_d   = '0;
      fail_d  = '0;
      err_d   = 1'b0;
    end else if (!mon.en && !halted) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          timer_d = TMR_LOAD;
        end
        ST_SETTLE: begin
          if (change) begin
            timer_d = TMR_LOAD;
          end else if (timer_q == TMR_ONE) begin
            state_d = ST_CHECK;
          end else begin
            timer_d = timer_q - TMR_ONE;
          end
        end
        ST_CHECK: begin
          if (change) begin
            state_d = ST_SETTLE;
            timer_d = TMR_LOAD;
          end else begin
            chk_d = sat_inc(chk_q);
            // A healthy inverter never has y equal to a.
            if (mon.y == mon.a) begin
              fail_d = sat_inc(fail_q);
              err_d  = 1'b1;
`ifdef INV_MON_HALT_EN
              state_d = ST_HALT;
`endif
            end
          end
        end
`ifdef INV_MON_HALT_EN
        ST_HALT: begin
          state_d = ST_HALT;
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
  end

  // State and output registers; a_q keeps sampling through clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      chk_q   <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      a_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      chk_q   <= chk_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      a_q     <= mon.a;
    end
  end

  assign mon.busy     = busy_q;
  assign mon.err      = err_q;
  assign mon.chk_cnt  = chk_q;
  assign mon.fail_cnt = fail_q;

endmodule
